// File: rtl/mem_loader.sv
// Host-side command sequencer for the CPU's external instruction/data SRAM ports.
// Executes one write, read or run-for-N-cycles command at a time and returns a single response.
module mem_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [63:0]       cmd_addr_i,
  input  logic [63:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [63:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              enable_o,
  output logic [63:0]       addr_ext_o,
  output logic              wen_ext_o,
  output logic              ren_ext_o,
  output logic [31:0]       wdata_ext_o,
  input  logic [31:0]       rdata_ext_i,
  output logic [63:0]       addr_ext_2_o,
  output logic              wen_ext_2_o,
  output logic              ren_ext_2_o,
  output logic [63:0]       wdata_ext_2_o,
  input  logic [63:0]       rdata_ext_2_i
);

  localparam int LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RUN,
    S_RESP
  } state_t;

  state_t             state_q;
  logic               dmem_q;
  logic [LAT_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]   run_n_q;
  logic [CNT_W-1:0]   run_cnt_q;
  logic [CNT_W-1:0]   run_cnt_d;
  logic               enable_q;
  logic               wen_q, ren_q, wen2_q, ren2_q;
  logic [63:0]        addr_q, addr2_q;
  logic [31:0]        wdata_q;
  logic [63:0]        wdata2_q;
  logic               rsp_valid_q;
  logic [63:0]        rsp_data_q;
  logic               rsp_err_q;

  assign run_cnt_d = run_cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      dmem_q      <= 1'b0;
      rd_cnt_q    <= '0;
      run_n_q     <= '0;
      run_cnt_q   <= '0;
      enable_q    <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      wen2_q      <= 1'b0;
      ren2_q      <= 1'b0;
      addr_q      <= '0;
      addr2_q     <= '0;
      wdata_q     <= '0;
      wdata2_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            dmem_q <= cmd_op_i[0];
            case (cmd_op_i)
              3'd0: begin
                state_q <= S_WRITE;
                wen_q   <= 1'b1;
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i[31:0];
              end
              3'd1: begin
                state_q  <= S_WRITE;
                wen2_q   <= 1'b1;
                addr2_q  <= cmd_addr_i;
                wdata2_q <= cmd_wdata_i;
              end
              3'd2: begin
                state_q  <= S_READ;
                ren_q    <= 1'b1;
                addr_q   <= cmd_addr_i;
                rd_cnt_q <= LAT_W'(RD_LAT);
              end
              3'd3: begin
                state_q  <= S_READ;
                ren2_q   <= 1'b1;
                addr2_q  <= cmd_addr_i;
                rd_cnt_q <= LAT_W'(RD_LAT);
              end
              3'd4: begin
                state_q   <= S_RUN;
                run_n_q   <= cmd_wdata_i[CNT_W-1:0];
                run_cnt_q <= '0;
                enable_q  <= |cmd_wdata_i[CNT_W-1:0];
              end
              default: begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        S_WRITE: begin
          wen_q       <= 1'b0;
          wen2_q      <= 1'b0;
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b0;
        end
        S_READ: begin
          ren_q  <= 1'b0;
          ren2_q <= 1'b0;
          // rdata is valid in the cycle where the wait counter has reached zero
          if (rd_cnt_q == '0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= dmem_q ? rdata_ext_2_i : {32'b0, rdata_ext_i};
            rsp_err_q   <= 1'b0;
          end else begin
            rd_cnt_q <= rd_cnt_q - LAT_W'(1);
          end
        end
        S_RUN: begin
          if (enable_q) begin
            run_cnt_q <= run_cnt_d;
            if (run_cnt_d == run_n_q) enable_q <= 1'b0;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 64'(run_cnt_q);
            rsp_err_q   <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Held low for the whole reset pulse, not just until the first clock edge.
  assign cmd_ready_o   = (state_q == S_IDLE) && !arst_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign enable_o      = enable_q;
  assign addr_ext_o    = addr_q;
  assign wen_ext_o     = wen_q;
  assign ren_ext_o     = ren_q;
  assign wdata_ext_o   = wdata_q;
  assign addr_ext_2_o  = addr2_q;
  assign wen_ext_2_o   = wen2_q;
  assign ren_ext_2_o   = ren2_q;
  assign wdata_ext_2_o = wdata2_q;

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Host-side initiator for the CPU's external memory-access ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and their _2 data-memory counterparts).
- Accepts a simple command stream: write or read instruction memory, write or read data memory, run the CPU for N cycles.
- Sequences the SRAM strobes and gates the CPU `enable`, then returns one response per command.
- Sits between the testbench/host link and the CPU top.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles (ren issue to rdata valid); legal range 1..3.
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  loader accepts command (transfer when cmd_valid & cmd_ready)
- cmd_op  in  3  0=WR_I, 1=WR_D, 2=RD_I, 3=RD_D, 4=RUN, 5..7 illegal
- cmd_addr  in  64  memory address (passed unmodified)
- cmd_wdata  in  64  write data; WR_I uses [31:0]; RUN uses [CNT_W-1:0] as cycle count
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  host accepts response
- rsp_data  out  64  read data (zero-extended for RD_I); 0 for writes; cycles executed for RUN
- rsp_err  out  1  1 for illegal opcode
- enable  out  1  CPU run enable
- addr_ext  out  64  instruction-memory address
- wen_ext  out  1  instruction-memory write strobe
- ren_ext  out  1  instruction-memory read strobe
- wdata_ext  out  32  instruction-memory write data
- rdata_ext  in  32  instruction-memory read data
- addr_ext_2  out  64  data-memory address
- wen_ext_2  out  1  data-memory write strobe
- ren_ext_2  out  1  data-memory read strobe
- wdata_ext_2  out  64  data-memory write data
- rdata_ext_2  in  64  data-memory read data

Behaviour:
- Reset (arst high, asynchronous):
  - State = IDLE.
  - All outputs 0, except cmd_ready = 1 once arst is released. cmd_ready is 0 while arst is high.
  - Any command in flight is dropped; `enable` drops in the same instant arst rises.
- State machine: IDLE, WRITE, READ, RUN, RESP. Registered outputs; all strobes are driven from state registers.
- IDLE:
  - cmd_ready = 1. On handshake, latch op, addr and wdata.
  - WR_* goes to WRITE, RD_* to READ, RUN to RUN.
  - Illegal op goes to RESP with rsp_err = 1 and rsp_data = 0.
- WRITE:
  - Exactly one cycle. Selected wen (wen_ext or wen_ext_2) = 1, with its addr and wdata valid in the same cycle.
  - Then go to RESP with rsp_data = 0.
- READ:
  - Selected ren = 1 in the first READ cycle only; addr is held for the whole READ state.
  - Wait counter runs RD_LAT cycles. rdata is captured on the edge that ends the RD_LAT-th cycle after the ren cycle.
  - Then go to RESP.
- RUN:
  - Count N is latched. If N = 0, go straight to RESP with rsp_data = 0; `enable` never asserts.
  - Otherwise `enable` = 1 for exactly N consecutive cycles, and a counter increments each enabled cycle.
  - After the N-th cycle: `enable` = 0, go to RESP, rsp_data = N (zero-extended).
  - All wen/ren are 0 during RUN.
- RESP:
  - rsp_valid = 1 with rsp_data and rsp_err stable.
  - On rsp_ready, return to IDLE; cmd_ready rises the next cycle. No back-to-back accept in the RESP exit cycle.
- Mutual exclusion: wen_ext, ren_ext, wen_ext_2, ren_ext_2 and `enable` are pairwise exclusive in every cycle. At most one SRAM strobe is ever high.
- Address/data outputs hold their last driven value while idle. Strobes are 0 outside their states.
- Single outstanding command; cmd_ready = 0 in every state except IDLE.
- Minimum command-to-response latency:
  - WR_*: 2 cycles (accept cycle, WRITE, rsp_valid).
  - RD_*: 2+RD_LAT cycles.
  - RUN: 2+N cycles.
- Counter wraps never occur: N is at most 2^CNT_W-1 and the counter stops at N.

Test Plan:
- Reset mid-RUN (N=100, arst at cycle 10): enable falls asynchronously; after release, state is IDLE, rsp_valid=0, cmd_ready=1.
- WR_I addr=0x8, wdata=0x00500093: exactly one cycle with wen_ext=1, addr_ext=0x8, wdata_ext=0x00500093; other strobes 0; rsp_data=0, rsp_err=0.
- WR_D addr=0x10, wdata=0xDEADBEEF_CAFEF00D, then RD_D addr=0x10 with RD_LAT=1 model SRAM:
  - Write: wen_ext_2 pulse.
  - Read: ren_ext_2 asserted for one cycle; rsp_data=0xDEADBEEF_CAFEF00D exactly 3 cycles after accept.
- RUN N=5 with rsp_ready held low 4 cycles:
  - enable high for exactly 5 cycles.
  - rsp_valid stays high with rsp_data=5 until rsp_ready.
  - cmd_ready is 0 throughout.
- RUN N=0 -> enable never rises; rsp_data=0 on the next RESP.
- cmd_op=6 -> rsp_err=1, rsp_data=0, no strobe or enable activity; the following RD_I addr=0x8 returns 0x00000000_00500093.
